weight_fetch_ctrl: RTL and testbench

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

---
 rtl/weight_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: clears the loader, then streams one kernel set from weight memory onto AXI-Stream.
// Optional feature macro: WEIGHT_FETCH_ABORT_EN adds an abort input that cancels a load in CLEAR/STREAM.
module weight_fetch_ctrl #(
    parameter int KERNEL_SIZE  = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BUS_WIDTH    = 32,
    parameter int NUM_KERNELS  = 4,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [(NUM_KERNELS > 1 ? $clog2(NUM_KERNELS) : 1)-1:0] kernel_sel,
`ifdef WEIGHT_FETCH_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [BUS_WIDTH-1:0]    mem_rd_data,
    output logic                    ld_rstn,
    output logic [BUS_WIDTH-1:0]    m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    start_err
);

    localparam int NUM_TRANSFERS = (KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int CNT_W         = $clog2(NUM_TRANSFERS + 1);

    if (NUM_KERNELS * NUM_TRANSFERS > (1 << ADDR_WIDTH)) begin : g_addr_overflow
        $error("weight_fetch_ctrl: NUM_KERNELS*NUM_TRANSFERS exceeds the ADDR_WIDTH address space");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  inflight;
    logic [BUS_WIDTH-1:0]  fifo_mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occ;
    logic                  push, pop, last_beat;
    logic                  abort_hit, abort_clr;

`ifdef WEIGHT_FETCH_ABORT_EN
    assign abort_hit = abort && (state == CLEAR || state == STREAM);
`else
    assign abort_hit = 1'b0;
`endif

    assign m_axis_tvalid = rstn && (fifo_cnt != 2'd0);
    assign m_axis_tdata  = fifo_mem[rd_ptr];
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = inflight;
    assign last_beat     = pop && (beat_cnt == CNT_W'(NUM_TRANSFERS - 1));
    assign mem_addr      = base + ADDR_WIDTH'(rd_cnt);

    // The entry leaving this cycle frees its slot, which is what allows 1 beat/cycle.
    assign occ = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, inflight};

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = abort_hit ? IDLE : STREAM;
            STREAM:  if (abort_hit)      state_nxt = IDLE;
                     else if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = 1'b0;
        ld_rstn   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (rstn) begin
            ld_rstn   = (state != CLEAR) && !abort_clr;
            busy      = (state != IDLE);
            done      = (state == DONE);
            mem_rd_en = (state == STREAM) && !abort_hit &&
                        (rd_cnt < CNT_W'(NUM_TRANSFERS)) && (occ < 3'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            base      <= '0;
            rd_cnt    <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            start_err <= 1'b0;
            abort_clr <= 1'b0;
        end else begin
            start_err <= start && (state != IDLE);
            abort_clr <= abort_hit;
            if (state == IDLE && start) begin
                base     <= ADDR_WIDTH'((int'(kernel_sel) % NUM_KERNELS) * NUM_TRANSFERS);
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end
            if (abort_hit) begin
                inflight <= 1'b0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                fifo_cnt <= 2'd0;
            end else begin
                inflight <= mem_rd_en;
                if (mem_rd_en) rd_cnt <= rd_cnt + 1'b1;
                if (pop) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    rd_ptr   <= ~rd_ptr;
                end
                if (push) wr_ptr <= ~wr_ptr;
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rd_data;
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: table of load scenarios plus reset/abort sequences.
module tb_weight_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  kernel_sel;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        ld_rstn;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy, done, start_err;
`ifdef WEIGHT_FETCH_ABORT_EN
    logic        abort;
`endif

    weight_fetch_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .kernel_sel(kernel_sel),
`ifdef WEIGHT_FETCH_ABORT_EN
        .abort(abort),
`endif
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .ld_rstn(ld_rstn), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .busy(busy), .done(done), .start_err(start_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] wdata(input int a);
        return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Memory model: data one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? wdata(int'(mem_addr)) : 32'hDEAD_BEEF;

    int tests = 0, fails = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int          addr_q[$];
    logic [31:0] data_q[$];
    int reads, beats, ld_low, done_cnt, err_cnt;
    int first_tv, last_beat, done_cyc, start_cyc;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data;

    always @(negedge clk) begin
        if (rstn) begin
            if (stall_prev)
                chk("stall_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, stall_data});
            if (mem_rd_en) begin
                reads++;
                if (addr_q.size() == 0) chk("unexpected_read", mem_addr, -1);
                else chk("rd_addr", mem_addr, addr_q.pop_front());
            end
            if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                last_beat = cyc;
                if (data_q.size() == 0) chk("unexpected_beat", m_axis_tdata, -1);
                else chk("beat_data", m_axis_tdata, data_q.pop_front());
            end
            if (mem_rd_en) chk("inflight_space", (reads - beats) <= 2, 1);
            if (!ld_rstn) ld_low++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (start_err) err_cnt++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
        end else begin
            stall_prev = 1'b0;
        end
    end

    typedef struct {
        logic [2:0] ksel;
        bit         rnd;
        int         exp_base;
        int         err_at;
        int         exp_err;
    } vec_t;

    task automatic do_load(input logic [2:0] ksel, input bit rnd, input int exp_base,
                           input int err_at, input int exp_err, input int stop_beat);
        int guard = 0;
        int tail  = -1;
        addr_q.delete();
        data_q.delete();
        for (int i = 0; i < 64; i++) begin
            addr_q.push_back(exp_base + i);
            data_q.push_back(wdata(exp_base + i));
        end
        reads = 0; beats = 0; ld_low = 0; done_cnt = 0; err_cnt = 0;
        first_tv = -1; last_beat = -1; done_cyc = -1;
        @(posedge clk); #1;
        kernel_sel    = ksel[1:0];
        start         = 1'b1;
        start_cyc     = cyc;
        m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (tail != 0) begin
            if (guard >= 3000) begin
                tests++; fails++;
                $display("FAIL load_timeout: got %0d beats expected 64", beats);
                start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            guard++;
            start = (err_at >= 0) && (cyc - start_cyc == err_at);
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            if (stop_beat >= 0 && beats >= stop_beat) begin
                start = 1'b0;
                m_axis_tready = 1'b1;
                return;
            end
            if (tail > 0) tail--;
            else if (done_cnt > 0) tail = 4;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        chk("beats", beats, 64);
        chk("reads", reads, 64);
        chk("done_pulses", done_cnt, 1);
        chk("ld_rstn_low_cycles", ld_low, 1);
        chk("start_err_pulses", err_cnt, exp_err);
        chk("data_left", data_q.size(), 0);
        chk("first_tvalid_latency", first_tv - start_cyc, 4);
        chk("done_after_last_beat", done_cyc - last_beat, 1);
        chk("busy_end", busy, 0);
        if (!rnd) chk("back_to_back", last_beat - first_tv, 63);
    endtask

    vec_t tbl[6];
    int   b0, r0;

    initial begin
        tbl[0] = '{3'd2, 1'b0, 128, -1, 0};  // basic load
        tbl[1] = '{3'd2, 1'b1, 128, -1, 0};  // random backpressure
        tbl[2] = '{3'd1, 1'b0,  64, 12, 1};  // start during STREAM
        tbl[3] = '{3'd5, 1'b0,  64, -1, 0};  // kernel_sel wraps
        tbl[4] = '{3'd3, 1'b1, 192, -1, 0};
        tbl[5] = '{3'd0, 1'b0,   0, 68, 1};  // start while in DONE

        rstn = 1'b0; start = 1'b0; kernel_sel = 2'd0; m_axis_tready = 1'b1;
`ifdef WEIGHT_FETCH_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start_err", start_err, 0);
        chk("rst_ld_rstn", ld_rstn, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_ld_rstn", ld_rstn, 1);

        foreach (tbl[i])
            do_load(tbl[i].ksel, tbl[i].rnd, tbl[i].exp_base, tbl[i].err_at, tbl[i].exp_err, -1);

        // Reset in the middle of a stream.
        do_load(3'd3, 1'b0, 192, -1, 0, 20);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_mem_rd_en", mem_rd_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_start_err", start_err, 0);
        chk("midrst_ld_rstn", ld_rstn, 0);
        @(posedge clk); #1;
        addr_q.delete();
        data_q.delete();
        b0 = beats; r0 = reads;
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_beats_after_rst", beats, b0);
        chk("no_reads_after_rst", reads, r0);
        do_load(3'd0, 1'b0, 0, -1, 0, -1);

`ifdef WEIGHT_FETCH_ABORT_EN
        do_load(3'd1, 1'b0, 64, -1, 0, 30);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_ld_rstn", ld_rstn, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        chk("abort_ld_rstn_release", ld_rstn, 1);
        addr_q.delete();
        data_q.delete();
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        do_load(3'd1, 1'b0, 64, -1, 0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
